// File: rtl/stack_bus_downstream_dist_if.sv
// Stack-bus downstream interface: manager command channel plus the per-PE delivery channel.
// slave is the distributor's view; master is the manager/PE-array side that drives commands and readies.
interface stack_bus_downstream_dist_if #(
   parameter int NUM_PE  = 64,
   parameter int PE_ID_W = 6,
   parameter int CMD_W   = 8,
   parameter int DATA_W  = 32
);
   logic                mgr__sbd__valid;
   logic                sbd__mgr__ready;
   logic [PE_ID_W-1:0]  mgr__sbd__peId;
   logic [CMD_W-1:0]    mgr__sbd__cmd;
   logic [DATA_W-1:0]   mgr__sbd__data;
   logic [NUM_PE-1:0]   sbd__pe__valid;
   logic [CMD_W-1:0]    sbd__pe__cmd;
   logic [DATA_W-1:0]   sbd__pe__data;
   logic [NUM_PE-1:0]   pe__sbd__ready;

   modport slave (
      input  mgr__sbd__valid, mgr__sbd__peId, mgr__sbd__cmd, mgr__sbd__data, pe__sbd__ready,
      output sbd__mgr__ready, sbd__pe__valid, sbd__pe__cmd, sbd__pe__data
   );

   modport master (
      output mgr__sbd__valid, mgr__sbd__peId, mgr__sbd__cmd, mgr__sbd__data, pe__sbd__ready,
      input  sbd__mgr__ready, sbd__pe__valid, sbd__pe__cmd, sbd__pe__data
   );
endinterface

// File: rtl/stack_bus_downstream_dist.sv
// Stack-bus downstream distributor: FIFO-buffers manager commands and hands each to its PE.
// STACK_BUS_DOWNSTREAM_BROADCAST_EN enables peId == all-ones as a broadcast to every PE.
//
// state    | meaning
// ST_IDLE  | pop FIFO head into output regs, route to SEND/BCAST or drop
// ST_SEND  | one-hot valid to the addressed PE until it accepts
// ST_BCAST | valid to every PE that has not yet accepted (broadcast build only)
module stack_bus_downstream_dist #(
   parameter int NUM_PE     = 64,
   parameter int PE_ID_W    = 6,
   parameter int CMD_W      = 8,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset_poweron,
   stack_bus_downstream_dist_if.slave    bus,
   output logic [7:0]                    sbd__sys__dropCount
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SEND  = 2'd1;
`ifdef STACK_BUS_DOWNSTREAM_BROADCAST_EN
   localparam logic [1:0] ST_BCAST = 2'd2;
`endif

   logic [PE_ID_W-1:0] mem_id   [FIFO_DEPTH];
   logic [CMD_W-1:0]   mem_cmd  [FIFO_DEPTH];
   logic [DATA_W-1:0]  mem_data [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count;

   logic [1:0]         state;
   logic [PE_ID_W-1:0] pe_id_q;
   logic [CMD_W-1:0]   cmd_q;
   logic [DATA_W-1:0]  data_q;
   logic [7:0]         drop_count;
   logic [NUM_PE-1:0]  valid;

   logic push, pop, fifo_ready;
   logic [PE_ID_W-1:0] head_id;
   logic id_all_ones, id_in_range;

`ifdef STACK_BUS_DOWNSTREAM_BROADCAST_EN
   logic [NUM_PE-1:0] ack_mask;
   logic [NUM_PE-1:0] accept_vec;
   assign accept_vec = valid & bus.pe__sbd__ready;
`endif

   // ready looks only at count, so a same-cycle pop never opens a slot
   assign fifo_ready  = (count != DEPTH_C);
   assign push        = bus.mgr__sbd__valid && fifo_ready;
   assign pop         = (state == ST_IDLE) && (count != '0);
   assign head_id     = mem_id[rd_ptr];
   assign id_all_ones = &head_id;
   assign id_in_range = !id_all_ones && (32'(head_id) < 32'(NUM_PE));

   always_ff @(posedge clk) begin
      if (push) begin
         mem_id[wr_ptr]   <= bus.mgr__sbd__peId;
         mem_cmd[wr_ptr]  <= bus.mgr__sbd__cmd;
         mem_data[wr_ptr] <= bus.mgr__sbd__data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_comb begin
      valid = '0;
      case (state)
         ST_SEND:  valid = {{(NUM_PE-1){1'b0}}, 1'b1} << pe_id_q;
`ifdef STACK_BUS_DOWNSTREAM_BROADCAST_EN
         ST_BCAST: valid = ~ack_mask;
`endif
         default:  valid = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_poweron) begin
         state      <= ST_IDLE;
         pe_id_q    <= '0;
         cmd_q      <= '0;
         data_q     <= '0;
         drop_count <= '0;
`ifdef STACK_BUS_DOWNSTREAM_BROADCAST_EN
         ack_mask   <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  pe_id_q <= head_id;
                  cmd_q   <= mem_cmd[rd_ptr];
                  data_q  <= mem_data[rd_ptr];
                  if (id_in_range) state <= ST_SEND;
`ifdef STACK_BUS_DOWNSTREAM_BROADCAST_EN
                  else if (id_all_ones) begin
                     state    <= ST_BCAST;
                     ack_mask <= '0;
                  end
`endif
                  else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
               end
            end
            ST_SEND: begin
               if (bus.pe__sbd__ready[pe_id_q]) state <= ST_IDLE;
            end
`ifdef STACK_BUS_DOWNSTREAM_BROADCAST_EN
            ST_BCAST: begin
               ack_mask <= ack_mask | accept_vec;
               if (&(ack_mask | accept_vec)) state <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.sbd__mgr__ready = fifo_ready;
   assign bus.sbd__pe__valid  = valid;
   assign bus.sbd__pe__cmd    = cmd_q;
   assign bus.sbd__pe__data   = data_q;
   assign sbd__sys__dropCount = drop_count;
endmodule

// File: tb/tb_stack_bus_downstream_dist.sv
// Directed bench for stack_bus_downstream_dist: unicast, backpressure, full FIFO, drop/broadcast, reset.
// Define STACK_BUS_DOWNSTREAM_BROADCAST_EN for the broadcast build; otherwise the drop case runs.
module tb_stack_bus_downstream_dist;
   logic       clk = 1'b0;
   logic       reset_poweron = 1'b1;
   logic [7:0] drop_count;
   int         n_tests = 0;
   int         n_fail  = 0;

   stack_bus_downstream_dist_if #(.NUM_PE(64), .PE_ID_W(6), .CMD_W(8), .DATA_W(32)) bus ();

   stack_bus_downstream_dist #(
      .NUM_PE(64), .PE_ID_W(6), .CMD_W(8), .DATA_W(32), .FIFO_DEPTH(8)
   ) dut (
      .clk                 (clk),
      .reset_poweron       (reset_poweron),
      .bus                 (bus.slave),
      .sbd__sys__dropCount (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] id, input logic [7:0] cmd, input logic [31:0] data);
      bus.mgr__sbd__valid = 1'b1;
      bus.mgr__sbd__peId  = id;
      bus.mgr__sbd__cmd   = cmd;
      bus.mgr__sbd__data  = data;
      tick();
      bus.mgr__sbd__valid = 1'b0;
   endtask

   initial begin
      int k;
      logic seen;
      bus.mgr__sbd__valid = 1'b0;
      bus.mgr__sbd__peId  = '0;
      bus.mgr__sbd__cmd   = '0;
      bus.mgr__sbd__data  = '0;
      bus.pe__sbd__ready  = '1;
      repeat (3) tick();
      reset_poweron = 1'b0;

      // reset state
      check("rst_valid", bus.sbd__pe__valid, 64'd0);
      check("rst_cmd",   64'(bus.sbd__pe__cmd), 64'd0);
      check("rst_data",  64'(bus.sbd__pe__data), 64'd0);
      check("rst_drop",  64'(drop_count), 64'd0);
      check("rst_ready", 64'(bus.sbd__mgr__ready), 64'd1);

      // unicast with N+2 latency
      push(6'd5, 8'h12, 32'hDEADBEEF);
      check("uc_n1_valid", bus.sbd__pe__valid, 64'd0);
      tick();
      check("uc_valid", bus.sbd__pe__valid, 64'd1 << 5);
      check("uc_cmd",   64'(bus.sbd__pe__cmd), 64'h12);
      check("uc_data",  64'(bus.sbd__pe__data), 64'hDEADBEEF);
      tick();
      check("uc_after", bus.sbd__pe__valid, 64'd0);

      // backpressure on PE 5
      bus.pe__sbd__ready = ~(64'd1 << 5);
      push(6'd5, 8'h34, 32'hCAFEF00D);
      tick();
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", bus.sbd__pe__valid, 64'd1 << 5);
         check("bp_cmd",   64'(bus.sbd__pe__cmd), 64'h34);
         check("bp_data",  64'(bus.sbd__pe__data), 64'hCAFEF00D);
         tick();
      end
      bus.pe__sbd__ready = '1;
      check("bp_acc_valid", bus.sbd__pe__valid, 64'd1 << 5);
      tick();
      check("bp_cleared", bus.sbd__pe__valid, 64'd0);

      // full FIFO: 8 buffered + 1 held in SEND
      bus.pe__sbd__ready = '0;
      for (int i = 0; i < 9; i++) begin
         check("full_rdy_before", 64'(bus.sbd__mgr__ready), 64'd1);
         bus.mgr__sbd__valid = 1'b1;
         bus.mgr__sbd__peId  = 6'd3;
         bus.mgr__sbd__cmd   = 8'h30 + 8'(i);
         bus.mgr__sbd__data  = 32'(i);
         tick();
      end
      check("full_rdy_low", 64'(bus.sbd__mgr__ready), 64'd0);
      bus.mgr__sbd__data = 32'd99;
      tick();
      check("full_rdy_still_low", 64'(bus.sbd__mgr__ready), 64'd0);
      bus.mgr__sbd__valid = 1'b0;
      bus.pe__sbd__ready  = '1;
      k = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.sbd__pe__valid != '0) begin
            check("full_dst",  bus.sbd__pe__valid, 64'd1 << 3);
            check("full_data", 64'(bus.sbd__pe__data), 64'(k));
            check("full_cmd",  64'(bus.sbd__pe__cmd), 64'(8'h30 + 8'(k)));
            k++;
         end
         tick();
      end
      check("full_count", 64'(k), 64'd9);
      check("full_rdy_back", 64'(bus.sbd__mgr__ready), 64'd1);

`ifdef STACK_BUS_DOWNSTREAM_BROADCAST_EN
      // broadcast: low half accepts first cycle, high half in cycle 4
      bus.pe__sbd__ready = '0;
      push(6'd63, 8'hB0, 32'h0BCA5701);
      tick();
      bus.pe__sbd__ready = {32'h0, 32'hFFFFFFFF};
      check("bc_c1_valid", bus.sbd__pe__valid, '1);
      check("bc_c1_data",  64'(bus.sbd__pe__data), 64'h0BCA5701);
      tick();
      bus.pe__sbd__ready = '0;
      check("bc_c2_valid", bus.sbd__pe__valid, {32'hFFFFFFFF, 32'h0});
      tick();
      check("bc_c3_valid", bus.sbd__pe__valid, {32'hFFFFFFFF, 32'h0});
      tick();
      bus.pe__sbd__ready = {32'hFFFFFFFF, 32'h0};
      check("bc_c4_valid", bus.sbd__pe__valid, {32'hFFFFFFFF, 32'h0});
      tick();
      check("bc_done", bus.sbd__pe__valid, 64'd0);
      // everyone accepts in the first cycle
      bus.pe__sbd__ready = '1;
      push(6'd63, 8'hB1, 32'h1);
      tick();
      check("bc1_valid", bus.sbd__pe__valid, '1);
      tick();
      check("bc1_done", bus.sbd__pe__valid, 64'd0);
      check("bc_no_drop", 64'(drop_count), 64'd0);
`else
      // all-ones id is out of range: dropped and counted
      push(6'd63, 8'hD0, 32'h0);
      check("drop_n1_valid", bus.sbd__pe__valid, 64'd0);
      tick();
      check("drop_one", 64'(drop_count), 64'd1);
      check("drop_valid", bus.sbd__pe__valid, 64'd0);
      seen = 1'b0;
      bus.mgr__sbd__valid = 1'b1;
      bus.mgr__sbd__peId  = 6'd63;
      for (int i = 0; i < 299; i++) begin
         if (bus.sbd__pe__valid != '0) seen = 1'b1;
         tick();
      end
      bus.mgr__sbd__valid = 1'b0;
      repeat (4) begin
         if (bus.sbd__pe__valid != '0) seen = 1'b1;
         tick();
      end
      check("drop_sat", 64'(drop_count), 64'd255);
      check("drop_no_valid", 64'(seen), 64'd0);
`endif

      // reset mid-SEND with 4 queued entries
      bus.pe__sbd__ready  = '0;
      bus.mgr__sbd__valid = 1'b1;
      bus.mgr__sbd__peId  = 6'd7;
      bus.mgr__sbd__cmd   = 8'h77;
      for (int i = 0; i < 5; i++) begin
         bus.mgr__sbd__data = 32'h100 + 32'(i);
         tick();
      end
      bus.mgr__sbd__valid = 1'b0;
      check("mr_pre_valid", bus.sbd__pe__valid, 64'd1 << 7);
      reset_poweron = 1'b1;
      tick();
      check("mr_valid", bus.sbd__pe__valid, 64'd0);
      check("mr_ready", 64'(bus.sbd__mgr__ready), 64'd1);
      check("mr_cmd",   64'(bus.sbd__pe__cmd), 64'd0);
      check("mr_drop",  64'(drop_count), 64'd0);
      reset_poweron = 1'b0;
      bus.pe__sbd__ready = '1;
      seen = 1'b0;
      repeat (12) begin
         if (bus.sbd__pe__valid != '0) seen = 1'b1;
         tick();
      end
      check("mr_no_replay", 64'(seen), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
